// File: rtl/regfile_pkg.sv
// regfile_pkg: constants shared by the 4-entry x 512-bit register file and
// its write-port arbiter, plus the saturating counter helper used by the
// optional statistics counters (REGFILE_ARB_STATS_EN).
package regfile_pkg;

  localparam int REG_COUNT = 4;
  localparam int DATA_W    = 512;
  localparam int ADDR_W    = 2;
  localparam int CNT_W     = 16;

  typedef logic [CNT_W-1:0] cnt_t;

  // Add a 0..3 increment to a counter, sticking at all-ones instead of wrapping.
  function automatic cnt_t sat_add(input cnt_t base, input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, base} + {{(CNT_W-1){1'b0}}, inc};
    if (sum[CNT_W]) begin
      sat_add = {CNT_W{1'b1}};
    end else begin
      sat_add = sum[CNT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_pick.sv
// regfile_write_arbiter_rr_pick: circular first-one finder. Starting at
// 'start' and wrapping modulo N, returns the first requester that is valid
// and not excluded, as a one-hot vector and as a binary index.
module regfile_write_arbiter_rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     valid,
  input  logic [PTR_W-1:0] start,
  input  logic [N-1:0]     exclude,
  output logic [N-1:0]     onehot,
  output logic [PTR_W-1:0] index,
  output logic             found
);

  logic [N-1:0] cand_s;

  assign cand_s = valid & ~exclude;

  // Walk the candidates in scan order and latch onto the first one seen.
  always_comb begin
    int pos;
    pos    = 0;
    onehot = '0;
    index  = '0;
    found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(start) + k) % N;
      if (!found && cand_s[pos]) begin
        found       = 1'b1;
        onehot[pos] = 1'b1;
        index       = PTR_W'(pos);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the two register-file write ports among
// NUM_REQ requesters. Up to two grants per cycle, round-robin, never two
// grants to the same address in one cycle. Port outputs are registered.
// Optional build macro REGFILE_ARB_STATS_EN adds saturating write_count and
// conflict_count outputs.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = regfile_pkg::DATA_W,
  parameter int ADDR_W  = regfile_pkg::ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         in1,
  output logic [DATA_W-1:0]         in2,
  output logic [ADDR_W-1:0]         write_addr1,
  output logic [ADDR_W-1:0]         write_addr2,
  output logic                      en1,
  output logic                      en2,
  output logic                      busy
`ifdef REGFILE_ARB_STATS_EN
  ,
  output logic [regfile_pkg::CNT_W-1:0] write_count,
  output logic [regfile_pkg::CNT_W-1:0] conflict_count
`endif
);

  import regfile_pkg::*;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Round-robin start point; advances past the last requester granted.
  logic [PTR_W-1:0]   rr_ptr_r;

  // Grant A (port 1)
  logic [NUM_REQ-1:0] onehot_a_s;
  logic [PTR_W-1:0]   idx_a_s;
  logic               found_a_s;
  logic [ADDR_W-1:0]  addr_a_s;
  logic [DATA_W-1:0]  data_a_s;

  // Grant B (port 2)
  logic [NUM_REQ-1:0] onehot_b_s;
  logic [PTR_W-1:0]   idx_b_s;
  logic               found_b_s;
  logic [ADDR_W-1:0]  addr_b_s;
  logic [DATA_W-1:0]  data_b_s;

  // Valid requesters targeting the same address as A (A included).
  logic [NUM_REQ-1:0] match_a_s;
  // Requesters B may not take: A itself and everyone colliding with A.
  logic [NUM_REQ-1:0] excl_b_s;

  // Index of the requester after idx, wrapping at NUM_REQ.
  function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] idx);
    if (idx == PTR_W'(NUM_REQ - 1)) begin
      ptr_after = '0;
    end else begin
      ptr_after = idx + PTR_W'(1);
    end
  endfunction

  regfile_write_arbiter_rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_pick_a (
    .valid   (req_valid),
    .start   (rr_ptr_r),
    .exclude ({NUM_REQ{1'b0}}),
    .onehot  (onehot_a_s),
    .index   (idx_a_s),
    .found   (found_a_s)
  );

  // B scans from the same start point; everything ahead of A in scan order
  // is already known to be idle, so excluding A gives "next after A".
  regfile_write_arbiter_rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_pick_b (
    .valid   (req_valid),
    .start   (rr_ptr_r),
    .exclude (excl_b_s),
    .onehot  (onehot_b_s),
    .index   (idx_b_s),
    .found   (found_b_s)
  );

  // Select the winners' payloads and flag requesters colliding with A's address.
  always_comb begin
    addr_a_s  = req_addr[int'(idx_a_s)*ADDR_W +: ADDR_W];
    data_a_s  = req_data[int'(idx_a_s)*DATA_W +: DATA_W];
    addr_b_s  = req_addr[int'(idx_b_s)*ADDR_W +: ADDR_W];
    data_b_s  = req_data[int'(idx_b_s)*DATA_W +: DATA_W];
    match_a_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && (req_addr[i*ADDR_W +: ADDR_W] == addr_a_s)) begin
        match_a_s[i] = 1'b1;
      end else begin
        match_a_s[i] = 1'b0;
      end
    end
  end

  assign excl_b_s = onehot_a_s | match_a_s;

  // Handshake back to requesters; nothing is accepted while reset is held.
  always_comb begin
    if (!reset_n) begin
      req_ready = '0;
    end else begin
      req_ready = onehot_a_s | onehot_b_s;
    end
  end

  // Register granted writes onto the ports; idle ports keep data/addr and drop en.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_r    <= '0;
      en1         <= 1'b0;
      en2         <= 1'b0;
      in1         <= '0;
      in2         <= '0;
      write_addr1 <= '0;
      write_addr2 <= '0;
      busy        <= 1'b0;
    end else begin
      if (found_a_s) begin
        en1         <= 1'b1;
        in1         <= data_a_s;
        write_addr1 <= addr_a_s;
      end else begin
        en1         <= 1'b0;
      end

      if (found_b_s) begin
        en2         <= 1'b1;
        in2         <= data_b_s;
        write_addr2 <= addr_b_s;
      end else begin
        en2         <= 1'b0;
      end

      busy <= found_a_s;

      // B always lies after A in scan order, so it is the last grant when present.
      if (found_b_s) begin
        rr_ptr_r <= ptr_after(idx_b_s);
      end else if (found_a_s) begin
        rr_ptr_r <= ptr_after(idx_a_s);
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

`ifdef REGFILE_ARB_STATS_EN
  logic       skip_s;
  logic [1:0] grant_cnt_s;

  // A cycle counts as a conflict when some valid requester other than A was
  // passed over only because it shares A's address.
  assign skip_s      = found_a_s & (|(match_a_s & ~onehot_a_s));
  assign grant_cnt_s = {1'b0, found_a_s} + {1'b0, found_b_s};

  // Saturating statistics, updated on the same edge the enables are pulsed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_count    <= '0;
      conflict_count <= '0;
    end else begin
      write_count    <= sat_add(write_count, grant_cnt_s);
      conflict_count <= sat_add(conflict_count, {1'b0, skip_s});
    end
  end
`endif

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the two write ports of the 4-entry, 512-bit register file among NUM_REQ independent requesters (ALU lanes, load unit, host loader). Each cycle it grants up to two requests round-robin and drives registered write-port signals (in1/in2, write_addr1/write_addr2, en1/en2) straight into the register file. It never presents the same address on both ports in one cycle, which removes write-write ambiguity in the file.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 512, write data width
- ADDR_W, 2, register address width
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester write request
- req_addr  in  NUM_REQ*ADDR_W  packed target addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  packed write data, same packing
- req_ready  out  NUM_REQ  combinational grant; transfer when valid&ready
- in1, in2  out  DATA_W  registered write data, ports 1/2
- write_addr1, write_addr2  out  ADDR_W  registered write addresses
- en1, en2  out  1  registered write enables, single-cycle pulses
- busy  out  1  registered; 1 when any grant occurred in the previous cycle

## Operation
- Round-robin pointer rr_ptr (clog2(NUM_REQ) bits), reset 0.
- Scan order each cycle: rr_ptr, rr_ptr+1, ... wrapping modulo NUM_REQ.
- Grant A: first valid requester in scan order. Grant B: next valid requester after A in scan order whose req_addr differs from A's.
- Requesters matching A's address, other than A itself, are skipped this cycle; they hold valid and are reconsidered next cycle.
- req_ready high only for A and B. With zero valid requests, no grant and ready all 0.
- A always maps to port 1, B to port 2. A single grant uses port 1 only.
- On a grant, the next rising edge registers data/addr into the port and pulses en for one cycle. Ports without a grant get en=0 and hold their previous data/addr.
- rr_ptr update: (index of last grant issued + 1) mod NUM_REQ. No update when there is no grant.
- req_ready must not depend on any req_ready output, so there is no combinational loop. req_valid may depend on req_ready only through registers.
- Invariant: en1&en2 implies write_addr1 != write_addr2.
- Requesters must keep addr/data stable while valid and not ready.

## Timing
- Grant is combinational in cycle N. en1/en2, in*, write_addr* are valid from edge N+1 through edge N+2.
- The register file samples on the falling edge inside cycle N+1, so total write latency is 1.5 cycles from handshake.
- Throughput: 2 writes/cycle when at least two valid requests target distinct addresses.
- Reset (reset_n low, any time including mid-burst): en1=en2=0, in1=in2=0, write_addr1=write_addr2=0, busy=0, rr_ptr=0, req_ready=0 while held. Any in-flight grant is dropped; requesters see no handshake during reset.
- First grant is possible in the first cycle after reset_n deasserts.

## Configuration
- REGFILE_ARB_STATS_EN defined: adds output write_count (16 bits) and output conflict_count (16 bits), both reset to 0 and saturating at 0xFFFF.
  - write_count increments by the number of enables pulsed (0/1/2).
  - conflict_count increments by 1 in each cycle where at least one requester was skipped for an address match.
- REGFILE_ARB_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package regfile_pkg holds REG_COUNT=4, DATA_W=512, ADDR_W=2, and the localparam for the counter width (16). The register file and this block both import it.
- One natural sub-module: rr_pick. It takes a valid mask, a start pointer and an exclude mask, and returns a one-hot first-found plus its index. It is instantiated twice: A, then B with A and A's address-matching requesters excluded.

## Test plan
- Reset then a single request: req0 valid, addr=2, data=0xA5..A5 → req_ready[0]=1 same cycle; next cycle en1=1, write_addr1=2, in1=0xA5..A5, en2=0; rr_ptr=1.
- Dual distinct: req1 addr=0, req2 addr=3 with rr_ptr=1 → both ready; port1=(0, data1), port2=(3, data2) one cycle later; rr_ptr=3.
- Same-address conflict: req0 and req1 both addr=1, rr_ptr=0 → only req0 granted; req1 granted next cycle on port1; en2 never high; en1&en2 with equal addresses never occurs.
- Fairness: all 4 requesters held valid with distinct addresses for 4 cycles → grant pairs (0,1),(2,3),(0,1),(2,3); each requester served twice.
- Reset mid-operation: assert reset_n low asynchronously in the cycle after a dual grant → en1/en2 drop to 0 immediately, ready=0 while reset is held; after release the scan restarts from requester 0.
- With REGFILE_ARB_STATS_EN: run the conflict and fairness sequences → write_count=10, conflict_count=1. Force 70000 writes → write_count stays at 0xFFFF.
